// File: rtl/io_request_arbiter_pkg.sv
// rtl/io_request_arbiter_pkg.sv - shared types for the non-cached I/O request path
//
// Purpose: request/response packet layouts, core id and bitmap types, and a
// one-hot-to-index helper used by the I/O request arbiter.
// Ports: none (package).

`ifndef NUM_CORES
`define NUM_CORES 4
`endif

package io_request_arbiter_pkg;

  localparam int NUM_CORES = `NUM_CORES;

  typedef logic [31:0]          scalar_t;
  typedef logic [3:0]           core_id_t;
  typedef logic [1:0]           thread_idx_t;
  typedef logic [NUM_CORES-1:0] core_bitmap_t;

  typedef struct packed {
    logic        store;
    thread_idx_t thread_idx;
    scalar_t     address;
    scalar_t     value;
  } ioreq_packet_t;

  typedef struct packed {
    core_id_t    core;
    thread_idx_t thread_idx;
    scalar_t     read_value;
  } iorsp_packet_t;

  // OR-reduction encoder; callers guarantee at most one bit is set.
  function automatic core_id_t oh_to_idx(input logic [15:0] oh);
    core_id_t idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) idx = idx | core_id_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/io_bus_interface.sv
// rtl/io_bus_interface.sv - shared non-cached I/O bus
//
// Purpose: single-master I/O bus. Read data is returned one cycle after read_en.
// Signals: write_en, read_en, address, write_data (master -> slave);
//          read_data (slave -> master).

interface io_bus_interface;
  logic        write_en;
  logic        read_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport master (output write_en, output read_en, output address,
                  output write_data, input read_data);
  modport slave  (input write_en, input read_en, input address,
                  input write_data, output read_data);
endinterface

// File: rtl/io_request_arbiter_rr.sv
// rtl/io_request_arbiter_rr.sv - round-robin arbiter with registered priority pointer
//
// Purpose: grants one requester per cycle; the requester after the last grant
// has the highest priority, wrapping NUM_REQUESTERS-1 -> 0.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset (core 0 highest after reset)
//   request        requester bitmap
//   update_lru     advance the priority pointer past the current winner
//   grant_oh       one-hot grant, all zero when nothing requests

module rr_arbiter #(
  parameter int NUM_REQUESTERS = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQUESTERS-1:0] request,
  input  logic                      update_lru,
  output logic [NUM_REQUESTERS-1:0] grant_oh
);

  localparam int IDX_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

  logic [IDX_W-1:0] priority_idx;
  logic [IDX_W-1:0] winner_idx;
  logic [IDX_W-1:0] next_priority;
  logic [IDX_W:0]   cand;
  logic             found;

  // Scan requesters starting at the priority pointer; cand carries one extra
  // bit so the modulo wrap works for non-power-of-two requester counts.
  always_comb begin
    grant_oh   = '0;
    winner_idx = '0;
    found      = 1'b0;
    cand       = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      cand = {1'b0, priority_idx} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_REQUESTERS)) cand = cand - (IDX_W+1)'(NUM_REQUESTERS);
      if (!found && request[cand[IDX_W-1:0]]) begin
        found      = 1'b1;
        winner_idx = cand[IDX_W-1:0];
      end
    end
    if (found) grant_oh[winner_idx] = 1'b1;
  end

  always_comb begin
    next_priority = '0;
    if (winner_idx != IDX_W'(NUM_REQUESTERS - 1)) next_priority = winner_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      priority_idx <= '0;
    end else if (update_lru && found) begin
      priority_idx <= next_priority;
    end
  end

endmodule

// File: rtl/io_request_arbiter.sv
// rtl/io_request_arbiter.sv - per-core I/O requests onto the shared I/O bus
//
// Purpose: round-robin arbitration of core I/O requests, registered bus drive,
// read-data capture and a broadcast response exactly 3 cycles after grant.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   ioreq_en       per-core request valid (held until acked)
//   ioreq          per-core request packets
//   ioreq_ack      one-hot combinational grant
//   io_bus         master side of the shared I/O bus
//   iorsp_valid    single-cycle response strobe
//   iorsp          response: core, thread_idx, read_value (0 for stores)

`ifndef NUM_CORES
`define NUM_CORES 4
`endif

module io_request_arbiter
  import io_request_arbiter_pkg::*;
#(
  parameter int NUM_CORES = `NUM_CORES
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_CORES-1:0] ioreq_en,
  input  ioreq_packet_t        ioreq [NUM_CORES],
  output logic [NUM_CORES-1:0] ioreq_ack,
  io_bus_interface.master      io_bus,
  output logic                 iorsp_valid,
  output iorsp_packet_t        iorsp
);

  logic [NUM_CORES-1:0] grant_oh;
  logic                 grant_any;
  core_id_t             grant_idx;
  ioreq_packet_t        grant_pkt;

  // Stage B/C sideband travelling alongside the bus transaction.
  logic        b_valid;
  core_id_t    b_core;
  thread_idx_t b_thread;
  logic        b_store;
  logic        c_valid;
  core_id_t    c_core;
  thread_idx_t c_thread;
  logic        c_store;

  rr_arbiter #(.NUM_REQUESTERS(NUM_CORES)) u_rr (
    .clk        (clk),
    .reset_n    (reset_n),
    .request    (ioreq_en),
    .update_lru (grant_any),
    .grant_oh   (grant_oh)
  );

  assign grant_any = |grant_oh;
  assign grant_idx = oh_to_idx(16'(grant_oh));
  // Acks are forced low during reset even if cores keep requesting.
  assign ioreq_ack = reset_n ? grant_oh : '0;

  always_comb begin
    grant_pkt = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (grant_oh[i]) grant_pkt = ioreq[i];
    end
  end

  // Stage B: drive the bus; address/write_data hold when idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      io_bus.write_en   <= 1'b0;
      io_bus.read_en    <= 1'b0;
      io_bus.address    <= '0;
      io_bus.write_data <= '0;
      b_valid           <= 1'b0;
      b_core            <= '0;
      b_thread          <= '0;
      b_store           <= 1'b0;
    end else begin
      io_bus.write_en <= grant_any & grant_pkt.store;
      io_bus.read_en  <= grant_any & ~grant_pkt.store;
      b_valid         <= grant_any;
      if (grant_any) begin
        io_bus.address    <= grant_pkt.address;
        io_bus.write_data <= grant_pkt.value;
        b_core            <= grant_idx;
        b_thread          <= grant_pkt.thread_idx;
        b_store           <= grant_pkt.store;
      end
    end
  end

  // Stage C: wait for read_data, which the bus returns one cycle after read_en.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_valid  <= 1'b0;
      c_core   <= '0;
      c_thread <= '0;
      c_store  <= 1'b0;
    end else begin
      c_valid <= b_valid;
      if (b_valid) begin
        c_core   <= b_core;
        c_thread <= b_thread;
        c_store  <= b_store;
      end
    end
  end

  // Response register: stores respond too, with a zero value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      iorsp_valid <= 1'b0;
      iorsp       <= '0;
    end else begin
      iorsp_valid <= c_valid;
      if (c_valid) begin
        iorsp.core       <= c_core;
        iorsp.thread_idx <= c_thread;
        iorsp.read_value <= c_store ? '0 : io_bus.read_data;
      end
    end
  end

endmodule

// File: tb/tb_io_request_arbiter.sv
// tb/tb_io_request_arbiter.sv - scoreboard bench for io_request_arbiter
//
// Purpose: directed stimulus pushes expected bus ops and responses into queues;
// a negedge monitor pops and compares whenever the DUT presents them.
// Ports: none (top-level bench).

module tb_io_request_arbiter;
  import io_request_arbiter_pkg::*;

  typedef struct {
    int          cyc;
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    int          cyc;
    logic [3:0]  core;
    logic [1:0]  thr;
    logic [31:0] val;
  } rsp_exp_t;

  logic          clk;
  logic          reset_n;
  logic [3:0]    en;
  ioreq_packet_t pk [4];
  logic [3:0]    ack;
  logic          iorsp_valid;
  iorsp_packet_t iorsp;

  io_bus_interface bus ();

  io_request_arbiter #(.NUM_CORES(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ioreq_en    (en),
    .ioreq       (pk),
    .ioreq_ack   (ack),
    .io_bus      (bus),
    .iorsp_valid (iorsp_valid),
    .iorsp       (iorsp)
  );

  int       total = 0;
  int       bad = 0;
  int       cyc = 0;
  logic [3:0] exp_ack = '0;
  bit       push_rsp = 1'b1;
  bit       fair_on = 1'b0;
  int       g0 = 0;
  int       g1 = 0;
  bus_exp_t bq[$];
  rsp_exp_t rq[$];
  bus_exp_t be;
  rsp_exp_t re;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    case (a)
      32'h100: return 32'hDEADBEEF;
      32'h10:  return 32'h1;
      32'h14:  return 32'h2;
      32'h18:  return 32'h3;
      default: return a ^ 32'h5A5A0000;
    endcase
  endfunction

  // Bus slave: data valid exactly one cycle after read_en, garbage otherwise.
  always @(posedge clk) begin
    if (bus.read_en) bus.read_data <= rd_model(bus.address);
    else             bus.read_data <= 32'hBAD00000 | 32'(cyc);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic set_req(input int c, input logic st, input logic [1:0] th,
                         input logic [31:0] a, input logic [31:0] v);
    pk[c].store      = st;
    pk[c].thread_idx = th;
    pk[c].address    = a;
    pk[c].value      = v;
    en[c]            = 1'b1;
  endtask

  // Issue one cycle with the hand-computed grant ea; the granted core drops.
  task automatic step(input logic [3:0] ea);
    bus_exp_t b;
    rsp_exp_t r;
    exp_ack = ea;
    for (int i = 0; i < 4; i++) begin
      if (ea[i]) begin
        b.cyc   = cyc + 1;
        b.we    = pk[i].store;
        b.re    = !pk[i].store;
        b.addr  = pk[i].address;
        b.wdata = pk[i].value;
        bq.push_back(b);
        if (push_rsp) begin
          r.cyc  = cyc + 3;
          r.core = 4'(i);
          r.thr  = pk[i].thread_idx;
          r.val  = pk[i].store ? 32'h0 : rd_model(pk[i].address);
          rq.push_back(r);
        end
      end
    end
    @(posedge clk);
    #1;
    en = en & ~ea;
  endtask

  task automatic rst_chk();
    chk("rst_ack", ack, 0);
    chk("rst_we", bus.write_en, 0);
    chk("rst_re", bus.read_en, 0);
    chk("rst_addr", bus.address, 0);
    chk("rst_wdata", bus.write_data, 0);
    chk("rst_rspv", iorsp_valid, 0);
    chk("rst_rsp", iorsp, 0);
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      chk("ack", ack, exp_ack);
      if (fair_on) begin
        g0 = g0 + int'(ack[0]);
        g1 = g1 + int'(ack[1]);
      end
      chk("we_re_exclusive", bus.write_en & bus.read_en, 0);
      if (bus.write_en || bus.read_en) begin
        if (bq.size() == 0) begin
          chk("bus_unexpected", 1, 0);
        end else begin
          be = bq.pop_front();
          chk("bus_cycle", cyc, be.cyc);
          chk("bus_we", bus.write_en, be.we);
          chk("bus_re", bus.read_en, be.re);
          chk("bus_addr", bus.address, be.addr);
          if (be.we) chk("bus_wdata", bus.write_data, be.wdata);
        end
      end
      if (iorsp_valid) begin
        if (rq.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          re = rq.pop_front();
          chk("rsp_cycle", cyc, re.cyc);
          chk("rsp_core", iorsp.core, re.core);
          chk("rsp_thread", iorsp.thread_idx, re.thr);
          chk("rsp_value", iorsp.read_value, re.val);
        end
      end
    end
  end

  initial begin
    reset_n = 1'b1;
    en = '0;
    for (int i = 0; i < 4; i++) pk[i] = '0;
    #2 reset_n = 1'b0;
    @(negedge clk);
    rst_chk();
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Single-core read, then store, then a core-3 read to bring the pointer to 0.
    set_req(2, 1'b0, 2'd1, 32'h100, 32'h0);
    step(4'b0100);
    set_req(0, 1'b1, 2'd3, 32'h2000, 32'h55AA);
    step(4'b0001);
    set_req(3, 1'b0, 2'd2, 32'h300, 32'h0);
    step(4'b1000);

    // Contention: cores 0,1,3 hold until acked.
    set_req(0, 1'b0, 2'd0, 32'h500, 32'h0);
    set_req(1, 1'b1, 2'd1, 32'h504, 32'h1111);
    set_req(3, 1'b0, 2'd3, 32'h508, 32'h0);
    step(4'b0001);
    step(4'b0010);
    step(4'b1000);

    // Fairness: cores 0 and 1 continuously for 8 cycles.
    set_req(0, 1'b1, 2'd0, 32'h400, 32'hA0);
    set_req(1, 1'b0, 2'd1, 32'h404, 32'h0);
    fair_on = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) begin
        step(4'b0001);
        set_req(0, 1'b1, 2'd0, 32'h600 + 32'(k * 8), 32'hB0 + 32'(k));
      end else begin
        step(4'b0010);
        set_req(1, 1'b0, 2'd1, 32'h604 + 32'(k * 8), 32'h0);
      end
    end
    fair_on = 1'b0;
    en = '0;
    chk("fair_core0", g0, 4);
    chk("fair_core1", g1, 4);

    // Back-to-back reads from core 1.
    set_req(1, 1'b0, 2'd2, 32'h10, 32'h0);
    step(4'b0010);
    set_req(1, 1'b0, 2'd2, 32'h14, 32'h0);
    step(4'b0010);
    set_req(1, 1'b0, 2'd2, 32'h18, 32'h0);
    step(4'b0010);
    for (int k = 0; k < 5; k++) step(4'b0000);
    chk("drain_bus_q", bq.size(), 0);
    chk("drain_rsp_q", rq.size(), 0);

    // Reset mid-flight: the in-flight read must never respond.
    push_rsp = 1'b0;
    set_req(2, 1'b0, 2'd1, 32'h700, 32'h0);
    step(4'b0100);
    step(4'b0000);
    reset_n = 1'b0;
    exp_ack = '0;
    en = 4'b0010;
    @(negedge clk);
    rst_chk();
    @(posedge clk);
    @(negedge clk);
    rst_chk();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    en = '0;
    push_rsp = 1'b1;

    // Pointer restarted at core 0: core 1 wins over core 3.
    set_req(1, 1'b0, 2'd0, 32'h800, 32'h0);
    set_req(3, 1'b1, 2'd3, 32'h804, 32'h77);
    step(4'b0010);
    step(4'b1000);
    for (int k = 0; k < 6; k++) step(4'b0000);
    chk("end_bus_q", bq.size(), 0);
    chk("end_rsp_q", rq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
